// File: rtl/led_fade_seq.sv
// ---------------------------------------------------------------------------
// led_fade_seq
//   LED brightness sequencer. Ramps channel levels up and back down, one
//   level step per 2^DIV_W unstalled clocks. The levels go out on an
//   Avalon-ST source, one beat per level change.
//   Mode 0 fades the channels one at a time, in turn; mode 1 fades all
//   channels together.
//
//   Optional feature: define LED_FADE_HOLD_EN to dwell HOLD_CYC clocks at
//   full brightness before ramping down. Without it, UP goes straight to
//   DOWN and there is no dwell counter.
//
// Parameters
//   NCH       number of LED channels (1..8)
//   DW        level width per channel
//   DIV_W     prescaler width
//   HOLD_CYC  peak dwell in clocks (LED_FADE_HOLD_EN only)
//
// Ports
//   csi_MCLK_clk      clock, rising edge
//   rsi_MRST_reset_n  asynchronous active-low reset
//   coe_EN            run enable
//   coe_MODE          0 = sequential per-channel fade, 1 = all together
//   aso_LEDS_ready    Avalon-ST sink ready
//   aso_LEDS_data     levels; channel 0 in the MSBs
//   aso_LEDS_valid    Avalon-ST valid
//   coe_CH            index of the active channel
// ---------------------------------------------------------------------------
module led_fade_seq #(
  parameter int unsigned NCH      = 3,
  parameter int unsigned DW       = 8,
  parameter int unsigned DIV_W    = 19,
  parameter int unsigned HOLD_CYC = 1024
) (
  input  logic                csi_MCLK_clk,
  input  logic                rsi_MRST_reset_n,
  input  logic                coe_EN,
  input  logic                coe_MODE,
  input  logic                aso_LEDS_ready,
  output logic [NCH*DW-1:0]   aso_LEDS_data,
  output logic                aso_LEDS_valid,
  output logic [2:0]          coe_CH
);

  localparam int unsigned DATA_W = NCH * DW;
  localparam logic [DW-1:0] LVL_MAX = {DW{1'b1}};

`ifdef LED_FADE_HOLD_EN
  localparam int unsigned HOLD_LAST = (HOLD_CYC > 1) ? HOLD_CYC - 1 : 0;
  localparam int unsigned HOLD_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;
`endif

  // Reject parameter sets the datapath cannot represent.
  if (NCH < 1 || NCH > 8 || DW < 1 || DIV_W < 1 || HOLD_CYC < 1) begin : g_bad_cfg
    $error("led_fade_seq: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP   = 3'd1,
    S_PEAK = 3'd2,
    S_DOWN = 3'd3,
    S_NEXT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       level_q, level_d;
  logic [2:0]          ch_q, ch_d;
  logic                mode_q, mode_d;
  logic [DIV_W-1:0]    presc_q, presc_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
`ifdef LED_FADE_HOLD_EN
  logic [HOLD_W-1:0]   dwell_q, dwell_d;
`endif

  logic stall;
  logic tick;
  logic beat;

  // A beat still waiting for the sink freezes everything time-based.
  assign stall = valid_q && !aso_LEDS_ready;
  assign tick  = (presc_q == {DIV_W{1'b1}}) && !stall;

  // Place a level on the bus: only the active channel in mode 0, every
  // channel in mode 1. Channel k sits at bits [(NCH-k)*DW-1 -: DW].
  function automatic logic [DATA_W-1:0] pack_levels(input logic [DW-1:0] lvl,
                                                    input logic          all_ch,
                                                    input logic [2:0]    ch);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (all_ch || (ch == 3'(k))) begin
        v[(NCH-k)*DW-1 -: DW] = lvl;
      end
    end
    return v;
  endfunction

  // Next-state, level and output-beat logic.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    ch_d    = ch_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    data_d  = data_q;
    valid_d = valid_q;
    beat    = 1'b0;
`ifdef LED_FADE_HOLD_EN
    dwell_d = '0;
`endif

    // Accepted beat retires; a fresh beat below re-asserts valid.
    if (valid_q && aso_LEDS_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        level_d = '0;
        ch_d    = 3'd0;
        presc_d = '0;
        if (coe_EN) begin
          mode_d  = coe_MODE;
          state_d = S_UP;
        end
      end

      S_UP: begin
        if (!stall) begin
          presc_d = presc_q + DIV_W'(1);
        end
        // Disable wins over a coincident tick: ramp down from where we are.
        if (!coe_EN) begin
          state_d = S_DOWN;
        end else if (tick) begin
          level_d = (level_q == LVL_MAX) ? LVL_MAX : level_q + DW'(1);
          beat    = 1'b1;
          if (level_d == LVL_MAX) begin
`ifdef LED_FADE_HOLD_EN
            state_d = S_PEAK;
`else
            state_d = S_DOWN;
`endif
          end
        end
      end

`ifdef LED_FADE_HOLD_EN
      S_PEAK: begin
        dwell_d = dwell_q;
        if (!stall) begin
          presc_d = presc_q + DIV_W'(1);
          if (dwell_q == HOLD_W'(HOLD_LAST)) begin
            state_d = S_DOWN;
          end else begin
            dwell_d = dwell_q + HOLD_W'(1);
          end
        end
      end
`endif

      S_DOWN: begin
        if (!stall) begin
          presc_d = presc_q + DIV_W'(1);
        end
        if (tick) begin
          level_d = (level_q == '0) ? '0 : level_q - DW'(1);
          beat    = 1'b1;
          if (level_d == '0) begin
            state_d = S_NEXT;
          end
        end
      end

      S_NEXT: begin
        // Advance by the mode that just finished, then adopt the new mode.
        if (!mode_q) begin
          ch_d = (ch_q == 3'(NCH - 1)) ? 3'd0 : ch_q + 3'd1;
        end
        mode_d = coe_MODE;
        if (coe_MODE) begin
          ch_d = 3'd0;
        end
        if (coe_EN) begin
          state_d = S_UP;
        end else begin
          state_d = S_IDLE;
          ch_d    = 3'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        level_d = '0;
        ch_d    = 3'd0;
        presc_d = '0;
        data_d  = '0;
        valid_d = 1'b0;
      end
    endcase

    // Every phase starts its step timing from zero.
    if (state_d != state_q) begin
      presc_d = '0;
`ifdef LED_FADE_HOLD_EN
      dwell_d = '0;
`endif
    end

    // Bus updates on the same edge as the level change.
    if (beat) begin
      data_d  = pack_levels(level_d, mode_q, ch_q);
      valid_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state_q <= S_IDLE;
      level_q <= '0;
      ch_q    <= 3'd0;
      mode_q  <= 1'b0;
      presc_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef LED_FADE_HOLD_EN
      dwell_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      ch_q    <= ch_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef LED_FADE_HOLD_EN
      dwell_q <= dwell_d;
`endif
    end
  end

  assign aso_LEDS_data  = data_q;
  assign aso_LEDS_valid = valid_q;
  assign coe_CH         = ch_q;

endmodule

// File: tb/tb_led_fade_seq.sv
// ---------------------------------------------------------------------------
// tb_led_fade_seq
//   Self-checking bench for led_fade_seq (NCH=3, DW=3, DIV_W=2, HOLD_CYC=4).
//   A behavioural model tracks brightness, active channel and the pending
//   bus beat cycle by cycle; directed scenarios add fixed expectations.
// ---------------------------------------------------------------------------
module tb_led_fade_seq;

  localparam int NCH      = 3;
  localparam int DW       = 3;
  localparam int DIV_W    = 2;
  localparam int HOLD_CYC = 4;
  localparam int DWID     = NCH * DW;
  localparam int PERIOD   = 1 << DIV_W;
  localparam int LMAX     = (1 << DW) - 1;
`ifdef LED_FADE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  // Model phases of a fade cycle.
  localparam int P_IDLE  = 0;
  localparam int P_RISE  = 1;
  localparam int P_DWELL = 2;
  localparam int P_FALL  = 3;
  localparam int P_GAP   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            mode;
  logic            rdy;
  logic [DWID-1:0] data;
  logic            valid;
  logic [2:0]      ch;

  led_fade_seq #(
    .NCH      (NCH),
    .DW       (DW),
    .DIV_W    (DIV_W),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .csi_MCLK_clk     (clk),
    .rsi_MRST_reset_n (rst_n),
    .coe_EN           (en),
    .coe_MODE         (mode),
    .aso_LEDS_ready   (rdy),
    .aso_LEDS_data    (data),
    .aso_LEDS_valid   (valid),
    .coe_CH           (ch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state.
  int m_ph, m_lvl, m_ch, m_mode, m_el, m_dw, m_data;
  bit m_valid;

  task automatic model_reset();
    m_ph = P_IDLE; m_lvl = 0; m_ch = 0; m_mode = 0;
    m_el = 0; m_dw = 0; m_data = 0; m_valid = 1'b0;
  endtask

  function automatic int pattern();
    int v;
    v = 0;
    for (int k = 0; k < NCH; k++) begin
      if (m_mode != 0 || k == m_ch) v += m_lvl << ((NCH - 1 - k) * DW);
    end
    return v;
  endfunction

  // One clock of intended behaviour, using the inputs the DUT will sample.
  task automatic model_step();
    bit stall, tick, beat;
    int nph;
    stall = m_valid && !rdy;
    tick  = !stall && (m_el == PERIOD - 1);
    beat  = 1'b0;
    nph   = m_ph;
    if (m_valid && rdy) m_valid = 1'b0;
    case (m_ph)
      P_IDLE: begin
        m_lvl = 0; m_ch = 0;
        if (en) begin m_mode = mode; nph = P_RISE; end
      end
      P_RISE: begin
        if (!en) nph = P_FALL;
        else if (tick) begin
          m_lvl = (m_lvl < LMAX) ? m_lvl + 1 : LMAX;
          beat = 1'b1;
          if (m_lvl == LMAX) nph = HOLD ? P_DWELL : P_FALL;
        end
      end
      P_DWELL: begin
        if (!stall) begin
          if (m_dw >= HOLD_CYC - 1) nph = P_FALL;
          else m_dw++;
        end
      end
      P_FALL: begin
        if (tick) begin
          m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
          beat = 1'b1;
          if (m_lvl == 0) nph = P_GAP;
        end
      end
      default: begin
        if (m_mode == 0) m_ch = (m_ch + 1) % NCH;
        m_mode = mode;
        if (m_mode != 0) m_ch = 0;
        if (en) nph = P_RISE;
        else begin nph = P_IDLE; m_ch = 0; end
      end
    endcase
    if ((m_ph == P_RISE || m_ph == P_DWELL || m_ph == P_FALL) && !stall)
      m_el = (m_el + 1) % PERIOD;
    if (nph != m_ph) begin m_el = 0; m_dw = 0; end
    m_ph = nph;
    if (beat) begin m_valid = 1'b1; m_data = pattern(); end
  endtask

  function automatic logic [DWID+3:0] got();
    return {data, valid, ch};
  endfunction

  function automatic logic [DWID+3:0] expv();
    return {DWID'(m_data), m_valid, 3'(m_ch)};
  endfunction

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    en = 1'b0; mode = 1'b0; rdy = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; mode = 1'b0; rdy = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (got() !== '0) begin
      errors++; $display("FAIL reset_async got=%h want=0", got());
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      adv(); checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, got(), expv());
      end
    end
  endtask

  task automatic test_seq_mode();
    int n;
    reset_dut();
    en = 1'b1; mode = 1'b0; rdy = 1'b1;
    n = 0;
    do begin
      adv(); n++; checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL seq_model cyc=%0d got=%h want=%h", n, got(), expv());
      end
    end while (data == '0 && n < 20);
    checks++;
    if (n != PERIOD + 1 || data !== 9'h040) begin
      errors++; $display("FAIL seq_first_tick clocks=%0d data=%h want clocks=%0d data=040", n, data, PERIOD + 1);
    end
    n = 0;
    while (data !== 9'h1C0 && n < 100) begin
      adv(); n++; checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL seq_model_up cyc=%0d got=%h want=%h", n, got(), expv());
      end
    end
    checks++;
    if (data !== 9'h1C0) begin
      errors++; $display("FAIL seq_ch0_peak data=%h want=1c0", data);
    end
    n = 0;
    while (data !== 9'h038 && n < 200) begin
      adv(); n++; checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL seq_model_ch1 cyc=%0d got=%h want=%h", n, got(), expv());
      end
    end
    checks++;
    if (data !== 9'h038 || ch !== 3'd1) begin
      errors++; $display("FAIL seq_ch1_peak data=%h ch=%0d want data=038 ch=1", data, ch);
    end
  endtask

  task automatic test_all_mode();
    int n;
    reset_dut();
    en = 1'b1; mode = 1'b1; rdy = 1'b1;
    n = 0;
    do begin
      adv(); n++; checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL all_model cyc=%0d got=%h want=%h", n, got(), expv());
      end
    end while (data == '0 && n < 20);
    checks++;
    if (data !== 9'h049) begin
      errors++; $display("FAIL all_first data=%h want=049", data);
    end
    n = 0;
    while (data !== 9'h1FF && n < 100) begin
      adv(); n++; checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL all_model_up cyc=%0d got=%h want=%h", n, got(), expv());
      end
    end
    checks++;
    if (data !== 9'h1FF || ch !== 3'd0) begin
      errors++; $display("FAIL all_peak data=%h ch=%0d want data=1ff ch=0", data, ch);
    end
    n = 0;
    while (data !== '0 && n < 100) begin
      adv(); n++; checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL all_model_down cyc=%0d got=%h want=%h", n, got(), expv());
      end
    end
    checks++;
    if (data !== '0 || ch !== 3'd0) begin
      errors++; $display("FAIL all_floor data=%h ch=%0d want data=000 ch=0", data, ch);
    end
  endtask

  task automatic test_stall();
    int n;
    reset_dut();
    en = 1'b1; mode = 1'b0; rdy = 1'b1;
    n = 0;
    while (data !== 9'h080 && n < 40) begin
      adv(); n++; checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL stall_model_pre cyc=%0d got=%h want=%h", n, got(), expv());
      end
    end
    checks++;
    if (data !== 9'h080) begin
      errors++; $display("FAIL stall_reach data=%h want=080", data);
    end
    rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      adv(); checks++;
      if (data !== 9'h080 || valid !== 1'b1 || got() !== expv()) begin
        errors++; $display("FAIL stall_hold cyc=%0d got=%h want data=080 valid=1 model=%h", i, got(), expv());
      end
    end
    rdy = 1'b1;
    n = 0;
    do begin
      adv(); n++; checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL stall_model_post cyc=%0d got=%h want=%h", n, got(), expv());
      end
    end while (data == 9'h080 && n < 20);
    checks++;
    if (n != PERIOD || data !== 9'h0C0) begin
      errors++; $display("FAIL stall_resume clocks=%0d data=%h want clocks=%0d data=0c0", n, data, PERIOD);
    end
  endtask

  task automatic test_en_drop();
    int n, cnt;
    logic [44:0]     seqv;
    logic [DWID-1:0] prev;
    reset_dut();
    en = 1'b1; mode = 1'b0; rdy = 1'b1;
    n = 0;
    while (data !== 9'h140 && n < 60) begin
      adv(); n++; checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL drop_model_pre cyc=%0d got=%h want=%h", n, got(), expv());
      end
    end
    en = 1'b0;
    seqv = '0; cnt = 0; prev = data;
    for (int i = 0; i < 40; i++) begin
      adv(); checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL drop_model cyc=%0d got=%h want=%h", i, got(), expv());
      end
      if (data !== prev) begin
        seqv = {seqv[35:0], data}; cnt++; prev = data;
      end
    end
    checks++;
    if (cnt != 5 || seqv !== {9'h100, 9'h0C0, 9'h080, 9'h040, 9'h000}) begin
      errors++; $display("FAIL drop_levels steps=%0d seq=%h want steps=5 seq=100,0c0,080,040,000", cnt, seqv);
    end
    checks++;
    if (got() !== '0) begin
      errors++; $display("FAIL drop_idle got=%h want=0", got());
    end
  endtask

  task automatic test_peak();
    int n;
    reset_dut();
    en = 1'b1; mode = 1'b0; rdy = 1'b1;
    n = 0;
    while (data !== 9'h1C0 && n < 60) begin
      adv(); n++; checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL peak_model_pre cyc=%0d got=%h want=%h", n, got(), expv());
      end
    end
    n = 0;
    do begin
      adv(); n++; checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL peak_model cyc=%0d got=%h want=%h", n, got(), expv());
      end
    end while (data == 9'h1C0 && n < 30);
    checks++;
    if (n != PERIOD + (HOLD ? HOLD_CYC : 0) || data !== 9'h180) begin
      errors++; $display("FAIL peak_dwell clocks=%0d data=%h want clocks=%0d data=180",
                         n, data, PERIOD + (HOLD ? HOLD_CYC : 0));
    end
  endtask

  // Runs right after test_peak, with channel 0 at level 6.
  task automatic test_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (got() !== '0) begin
      errors++; $display("FAIL reset_mid_async got=%h want=0", got());
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; checks++;
      if (got() !== '0) begin
        errors++; $display("FAIL reset_mid_hold cyc=%0d got=%h want=0", i, got());
      end
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    reset_dut();
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if (en) begin
        if ($urandom_range(0, 99) == 0) en = 1'b0;
      end else begin
        if ($urandom_range(0, 9) == 0) en = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      adv(); checks++;
      if (got() !== expv()) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", i, got(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq_mode();
    test_all_mode();
    test_stall();
    test_en_drop();
    test_peak();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
